// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop engine: FSM state encoding and row padding.
package crop_pkg;

    typedef logic [2:0] crop_state_t;

    localparam crop_state_t S_IDLE  = 3'd0;
    localparam crop_state_t S_CHECK = 3'd1;
    localparam crop_state_t S_READ  = 3'd2;
    localparam crop_state_t S_WAIT  = 3'd3;
    localparam crop_state_t S_WRITE = 3'd4;
    localparam crop_state_t S_PAD   = 3'd5;
    localparam crop_state_t S_DONE  = 3'd6;

    // Component counter width; BPP is limited to 1..4.
    localparam int unsigned C_W = 2;

    // Zero bytes needed to bring a row up to a 4-byte multiple.
    function automatic logic [1:0] pad_bytes(input logic [31:0] row_bytes);
        return 2'(3'd4 - {1'b0, row_bytes[1:0]});
    endfunction

endpackage

// File: rtl/crop_addr_gen.sv
// Window walker: x/y/component counters and the source byte address of the next read.
module crop_addr_gen
    import crop_pkg::*;
#(
    parameter int unsigned WIDTH   = 100,
    parameter int unsigned BPP     = 3,
    parameter int unsigned COORD_W = 11,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_next_row,
    input  logic [COORD_W-1:0] i_x_min,
    input  logic [COORD_W-1:0] i_x_max,
    input  logic [COORD_W-1:0] i_y_min,
    input  logic [COORD_W-1:0] i_y_max,
    input  logic               i_mirror,
    output logic [ADDR_W-1:0]  o_addr_c,
    output logic               o_last_byte_c,
    output logic               o_last_row_c
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [C_W-1:0]     r_c;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic [C_W-1:0]     w_c_nxt;
    logic [COORD_W-1:0] w_x_first;
    logic [COORD_W-1:0] w_x_last;
    logic               w_c_last;

    assign w_x_first = i_mirror ? i_x_max : i_x_min;
    assign w_x_last  = i_mirror ? i_x_min : i_x_max;
    assign w_c_last  = (r_c == C_W'(BPP - 1));

    assign o_last_byte_c = w_c_last && (r_x == w_x_last);
    assign o_last_row_c  = (r_y == i_y_min);

    // Next position; components stay in source order regardless of mirroring.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_c_nxt = r_c;
        if (i_load) begin
            w_x_nxt = w_x_first;
            w_y_nxt = i_y_max;
            w_c_nxt = '0;
        end else if (i_next_row) begin
            w_x_nxt = w_x_first;
            w_y_nxt = r_y - COORD_W'(1);
            w_c_nxt = '0;
        end else if (i_step) begin
            if (!w_c_last) begin
                w_c_nxt = r_c + C_W'(1);
            end else begin
                w_c_nxt = '0;
                w_x_nxt = i_mirror ? (r_x - COORD_W'(1)) : (r_x + COORD_W'(1));
            end
        end
    end

    // Address is formed from the next position so the top can register it on READ entry.
    assign o_addr_c = (ADDR_W'(w_y_nxt) * ADDR_W'(WIDTH) + ADDR_W'(w_x_nxt)) * ADDR_W'(BPP)
                      + ADDR_W'(w_c_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
            r_c <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_c <= w_c_nxt;
        end
    end

endmodule

// File: rtl/crop_engine.sv
// Crop engine: copies a validated source window bottom-up into a 4-byte padded BMP pixel array.
module crop_engine
    import crop_pkg::*;
#(
    parameter int unsigned WIDTH    = 100,
    parameter int unsigned HEIGHT   = 100,
    parameter int unsigned BPP      = 3,
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned OUT_BASE = 54,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x_min,
    input  logic [COORD_W-1:0] i_x_max,
    input  logic [COORD_W-1:0] i_y_min,
    input  logic [COORD_W-1:0] i_y_max,
    input  logic               i_mirror_x,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [ADDR_W-1:0]  o_rd_addr,
    output logic               o_rd_en,
    input  logic [7:0]         i_rd_data,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [7:0]         o_wr_data,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_out_bytes
);

    localparam int unsigned LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int unsigned LAT_INIT = (RD_LAT > 1) ? (RD_LAT - 2) : 0;

    crop_state_t        r_state;
    crop_state_t        w_state_nxt;
    logic [COORD_W-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic               r_mirror;
    logic [ADDR_W-1:0]  r_ptr;
    logic [LAT_W-1:0]   r_lat;
    logic [1:0]         r_pad_left;
    logic               r_wr_pad;
    logic               r_busy, r_done, r_err, r_rd_en, r_wr_en;
    logic [ADDR_W-1:0]  r_rd_addr, r_wr_addr, r_out_bytes;

    logic               w_load, w_step, w_next_row;
    logic               w_invalid, w_last_byte, w_last_row;
    logic [ADDR_W-1:0]  w_addr_nxt, w_row_bytes;
    logic [1:0]         w_pad;
    logic [COORD_W-1:0] w_cfg_x_min, w_cfg_x_max, w_cfg_y_min, w_cfg_y_max;
    logic               w_cfg_mirror;

    // The walker sees the live inputs on the load cycle, the latched window afterwards.
    assign w_cfg_x_min  = w_load ? i_x_min    : r_x_min;
    assign w_cfg_x_max  = w_load ? i_x_max    : r_x_max;
    assign w_cfg_y_min  = w_load ? i_y_min    : r_y_min;
    assign w_cfg_y_max  = w_load ? i_y_max    : r_y_max;
    assign w_cfg_mirror = w_load ? i_mirror_x : r_mirror;

    assign w_invalid = (r_x_min > r_x_max) || (r_y_min > r_y_max) ||
                       (r_x_max >= COORD_W'(WIDTH)) || (r_y_max >= COORD_W'(HEIGHT));
    assign w_row_bytes = (ADDR_W'(r_x_max) - ADDR_W'(r_x_min) + ADDR_W'(1)) * ADDR_W'(BPP);
    assign w_pad       = pad_bytes(32'(w_row_bytes));

    crop_addr_gen #(
        .WIDTH   (WIDTH),
        .BPP     (BPP),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_next_row    (w_next_row),
        .i_x_min       (w_cfg_x_min),
        .i_x_max       (w_cfg_x_max),
        .i_y_min       (w_cfg_y_min),
        .i_y_max       (w_cfg_y_max),
        .i_mirror      (w_cfg_mirror),
        .o_addr_c      (w_addr_nxt),
        .o_last_byte_c (w_last_byte),
        .o_last_row_c  (w_last_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_next_row  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_CHECK;
                    w_load      = 1'b1;
                end
            end
            S_CHECK: w_state_nxt = w_invalid ? S_DONE : S_READ;
            S_READ:  w_state_nxt = (RD_LAT == 1) ? S_WRITE : S_WAIT;
            S_WAIT: begin
                if (r_lat == '0) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (!w_last_byte) begin
                    w_step      = 1'b1;
                    w_state_nxt = S_READ;
                end else if (w_pad != 2'd0) begin
                    w_state_nxt = S_PAD;
                end else if (w_last_row) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_next_row  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_PAD: begin
                if (r_pad_left == 2'd1) begin
                    if (w_last_row) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_next_row  = 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with READ/WRITE/PAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_mirror    <= 1'b0;
            r_ptr       <= '0;
            r_lat       <= '0;
            r_pad_left  <= '0;
            r_wr_pad    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_out_bytes <= '0;
        end else begin
            r_rd_en  <= (w_state_nxt == S_READ);
            r_wr_en  <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_PAD);
            r_wr_pad <= (w_state_nxt == S_PAD);
            if (w_state_nxt == S_READ) r_rd_addr <= w_addr_nxt;
            if ((w_state_nxt == S_WRITE) || (w_state_nxt == S_PAD)) begin
                r_wr_addr <= r_ptr;
                r_ptr     <= r_ptr + ADDR_W'(1);
            end
            if (w_load) begin
                r_x_min     <= i_x_min;
                r_x_max     <= i_x_max;
                r_y_min     <= i_y_min;
                r_y_max     <= i_y_max;
                r_mirror    <= i_mirror_x;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_out_bytes <= '0;
                r_ptr       <= ADDR_W'(OUT_BASE);
            end
            if (r_state == S_READ)      r_lat <= LAT_W'(LAT_INIT);
            else if (r_state == S_WAIT) r_lat <= r_lat - LAT_W'(1);
            if ((r_state == S_WRITE) && (w_state_nxt == S_PAD)) r_pad_left <= w_pad;
            else if (r_state == S_PAD)                          r_pad_left <= r_pad_left - 2'd1;
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_err       <= (r_state == S_CHECK);
                r_out_bytes <= (r_state == S_CHECK) ? '0 : (r_ptr - ADDR_W'(OUT_BASE));
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_out_bytes = r_out_bytes;
    // Source data arrives in the WRITE cycle itself, so it is forwarded rather than registered.
    assign o_wr_data   = (r_wr_en && !r_wr_pad) ? i_rd_data : 8'h00;

endmodule
